// File: rtl/apb_master_sched_pkg.sv
// Shared types and constants for the two-requester APB master scheduler.
package apb_sched_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_S0   = 3'b001;
    localparam logic [2:0] PSEL_S1   = 3'b010;
    localparam logic [2:0] PSEL_S2   = 3'b100;

    // Decode-field value that maps to no peripheral.
    localparam logic [1:0] SEL_ERR_CODE = 2'd3;

    function automatic logic [2:0] decode_sel(input logic [1:0] field);
        case (field)
            2'd0:    return PSEL_S0;
            2'd1:    return PSEL_S1;
            2'd2:    return PSEL_S2;
            default: return PSEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/apb_master_sched_if.sv
// Requester handshake plus APB bus bundle; master = scheduler side.
interface apb_master_sched_if
    import apb_sched_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_rdata;
    logic                           rsp_err;
    logic [ADDR_W-1:0]              PADDR;
    logic [DATA_W-1:0]              PWDATA;
    logic                           PWRITE;
    logic [2:0]                     PSELX;
    logic                           PENABLE;
    logic [DATA_W-1:0]              PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDR, PWDATA, PWRITE, PSELX, PENABLE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDR, PWDATA, PWRITE, PSELX, PENABLE
    );
endinterface

// File: rtl/apb_master_sched_arb.sv
// Two-input round-robin arbiter; pointer remembers the last granted requester.
module apb_rr_arb
    import apb_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);
    logic last_q;

    // On contention the requester not granted last wins.
    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end

    // Reset value "last was 1" makes requester 0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance_i) begin
            last_q <= grant_o[1];
        end
    end
endmodule

// File: rtl/apb_master_sched.sv
// Arbitrates two requesters onto one APB bus and sequences SETUP/ACCESS phases.
module apb_master_sched
    import apb_sched_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = 8
)(
    input  logic               clk,
    input  logic               PRESETn,
    apb_master_sched_if.master bus
);
    state_e              state_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                pwrite_q;
    logic [2:0]          psel_q;
    logic                penable_q;
    logic                owner_q;
    logic                err_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic                accept;
    logic                handshake;
    logic                gnt_idx;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  ready;
    logic [ADDR_W-1:0]   sel_addr;
    logic [1:0]          sel_field;

    apb_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (PRESETn),
        .req_i     (bus.req_valid),
        .advance_i (handshake),
        .grant_o   (grant)
    );

    assign accept    = (state_q == ST_IDLE) || (state_q == ST_ACCESS);
    assign ready     = accept ? grant : '0;
    assign handshake = |ready;
    assign gnt_idx   = grant[1];
    assign sel_addr  = bus.req_addr[gnt_idx];
    assign sel_field = sel_addr[SEL_LSB+1:SEL_LSB];

    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= PSEL_NONE;
            penable_q   <= 1'b0;
            owner_q     <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= ~err_q;
                end
                ST_ACCESS: begin
                    state_q     <= ST_IDLE;
                    psel_q      <= PSEL_NONE;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    rsp_err_q   <= err_q;
                    rsp_rdata_q <= (pwrite_q || err_q) ? '0 : bus.PRDATA;
                end
                default: ;
            endcase
            // A handshake in ACCESS overrides the IDLE return for back-to-back flow.
            if (handshake) begin
                state_q  <= ST_SETUP;
                paddr_q  <= sel_addr;
                pwdata_q <= bus.req_wdata[gnt_idx];
                pwrite_q <= bus.req_write[gnt_idx];
                owner_q  <= gnt_idx;
                err_q    <= (sel_field == SEL_ERR_CODE);
                psel_q   <= decode_sel(sel_field);
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSELX     = psel_q;
    assign bus.PENABLE   = penable_q;
endmodule

// File: tb/tb_apb_master_sched.sv
// Directed bench for apb_master_sched: vector table plus back-to-back and reset sequences.
module tb_apb_master_sched;
    import apb_sched_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic PRESETn = 1'b0;
    always #5 clk = ~clk;

    apb_master_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_sched #(.ADDR_W(AW), .DATA_W(DW), .SEL_LSB(8)) dut (
        .clk     (clk),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          req;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic [2:0]  psel;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[5];
    vec_t post_rst;

    task automatic run_vec(input vec_t v);
        logic [1:0] one_hot;
        one_hot = v.req ? 2'b10 : 2'b01;
        @(negedge clk);
        bus.req_valid          = one_hot;
        bus.req_write[v.req]   = v.wr;
        bus.req_addr[v.req]    = v.addr;
        bus.req_wdata[v.req]   = v.wdata;
        bus.PRDATA             = v.prdata;
        #1;
        chk("ready", 32'(bus.req_ready), 32'(one_hot));
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("setup_psel",    32'(bus.PSELX),     32'(v.psel));
        chk("setup_penable", 32'(bus.PENABLE),   32'd0);
        chk("setup_paddr",   bus.PADDR,          v.addr);
        chk("setup_pwrite",  32'(bus.PWRITE),    32'(v.wr));
        chk("setup_rspv",    32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("access_penable", 32'(bus.PENABLE),  v.err ? 32'd0 : 32'd1);
        chk("access_psel",    32'(bus.PSELX),    32'(v.psel));
        chk("access_pwdata",  bus.PWDATA,        v.wdata);
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(one_hot));
        chk("rsp_rdata", bus.rsp_rdata,      v.rdata);
        chk("rsp_err",   32'(bus.rsp_err),   32'(v.err));
        chk("idle_psel", 32'(bus.PSELX),     32'd0);
        chk("idle_pen",  32'(bus.PENABLE),   32'd0);
        $display("txn req%0d %s addr=%h psel=%b rdata=%h err=%0d",
                 v.req, v.wr ? "WR" : "RD", v.addr, bus.PSELX, bus.rsp_rdata, bus.rsp_err);
        @(negedge clk);
        chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    endtask

    // Back-to-back bookkeeping
    int          cnt[2];
    int          exp_gnt;
    int          first_hs;
    int          last_rsp;
    int          rsp_n;
    int          owner_q[$];
    logic [31:0] acc_rd;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req wr addr           wdata          prdata         psel    err rdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3'b010, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'hFFFF_FFFF, 3'b001, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0,         32'h55AA_55AA, 3'b000, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0,         32'hCAFE_0001, 3'b100, 1'b0, 32'hCAFE_0001};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_01FC, 32'hA5A5_0F0F, 32'h1111_1111, 3'b010, 1'b0, 32'h0};
        post_rst = '{1'b1, 1'b0, 32'h0000_0208, 32'h0,        32'h0BAD_F00D, 3'b100, 1'b0, 32'h0BAD_F00D};

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_psel",  32'(bus.PSELX),     32'd0);
        chk("rst_pen",   32'(bus.PENABLE),   32'd0);
        chk("rst_paddr", bus.PADDR,          32'd0);
        chk("rst_rspv",  32'(bus.rsp_valid), 32'd0);
        PRESETn = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("rst_rr_favour0", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Both requesters valid continuously, 4 reads each
        cnt[0] = 0; cnt[1] = 0; exp_gnt = 0; first_hs = -1; last_rsp = -1; rsp_n = 0; acc_rd = '0;
        bus.req_write = 2'b00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) begin
                int own;
                own = (owner_q.size() > 0) ? owner_q.pop_front() : 0;
                chk("b2b_rsp_owner", 32'(bus.rsp_valid), own ? 32'd2 : 32'd1);
                chk("b2b_rsp_rdata", bus.rsp_rdata, acc_rd);
                $display("txn b2b rsp owner=%0d rdata=%h cycle=%0d", own, bus.rsp_rdata, c);
                last_rsp = c;
                rsp_n++;
            end
            if (first_hs >= 0 && c > first_hs && c <= first_hs + 16) begin
                chk("b2b_no_idle", 32'(bus.PSELX != 3'b000), 32'd1);
            end
            if (rsp_n == 8) break;
            bus.PRDATA = 32'hB000_0000 + 32'(c);
            if (bus.PENABLE) acc_rd = bus.PRDATA;
            bus.req_valid   = {cnt[1] < 4, cnt[0] < 4};
            bus.req_addr[0] = 32'h0000_0010 + 32'(cnt[0] * 4);
            bus.req_addr[1] = 32'h0000_0200 + 32'(cnt[1] * 4);
            #1;
            if (bus.req_ready != 2'b00) begin
                chk("b2b_grant", 32'(bus.req_ready), exp_gnt ? 32'd2 : 32'd1);
                cnt[bus.req_ready[1]]++;
                owner_q.push_back(int'(bus.req_ready[1]));
                if (first_hs < 0) first_hs = c;
                exp_gnt = 1 - exp_gnt;
            end
        end
        bus.req_valid = 2'b00;
        chk("b2b_rsp_count", 32'(rsp_n), 32'd8);
        chk("b2b_span", 32'(last_rsp - first_hs), 32'd17);

        // Reset asserted during ACCESS
        @(negedge clk);
        bus.req_valid   = 2'b01;
        bus.req_addr[0] = 32'h0000_0100;
        bus.req_write   = 2'b00;
        bus.PRDATA      = 32'h0000_0077;
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("mid_access_pen", 32'(bus.PENABLE), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_psel",   32'(bus.PSELX),     32'd0);
        chk("arst_pen",    32'(bus.PENABLE),   32'd0);
        chk("arst_paddr",  bus.PADDR,          32'd0);
        chk("arst_pwdata", bus.PWDATA,         32'd0);
        chk("arst_pwrite", 32'(bus.PWRITE),    32'd0);
        chk("arst_rspv",   32'(bus.rsp_valid), 32'd0);
        chk("arst_rdata",  bus.rsp_rdata,      32'd0);
        $display("txn reset during ACCESS");
        @(negedge clk);
        chk("arst_hold_rspv", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        PRESETn = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("arst_rr_favour0", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        run_vec(post_rst);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
